// File: rtl/pmu_regs.sv
// pmu_regs: PMU register block with a wakeup timer, accessed through a 4-phase
// request/acknowledge handshake from an APB-domain bridge.
//
// Ports:
//   pmu_clk      slow PMU clock, all state rising-edge clocked
//   pmu_resetn   asynchronous active-low reset
//   pmu_pvalid   access request (asynchronous to pmu_clk, synchronized here)
//   pmu_pwrite   1 = write, 0 = read (stable while pmu_pvalid or pmu_ack is high)
//   pmu_paddr    word address [7:2]
//   pmu_pwdata   write data
//   pmu_ack      handshake acknowledge (registered)
//   pmu_prdata   read data (registered, updated only by a read access)
//   pmu_irq      wakeup-timer interrupt, level (registered expired & irq_en)
//
// Register map (byte offset): 0x00 CTRL {reload, irq_en, en}, 0x04 LOAD,
// 0x08 COUNT (RO), 0x0C STATUS {expired} W1C, 0x10 ID (RO).
module pmu_regs #(
    parameter int unsigned D      = 0,
    parameter logic [31:0] PMU_ID = 32'h504D_0001
) (
    input  logic        pmu_clk,
    input  logic        pmu_resetn,
    input  logic        pmu_pvalid,
    input  logic        pmu_pwrite,
    input  logic [7:2]  pmu_paddr,
    input  logic [31:0] pmu_pwdata,
    output logic        pmu_ack,
    output logic [31:0] pmu_prdata,
    output logic        pmu_irq
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 6;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(6'h00);
    localparam logic [ADDR_W-1:0] ADDR_LOAD   = ADDR_W'(6'h01);
    localparam logic [ADDR_W-1:0] ADDR_COUNT  = ADDR_W'(6'h02);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(6'h03);
    localparam logic [ADDR_W-1:0] ADDR_ID     = ADDR_W'(6'h04);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    // D has no functional effect; it is only folded into an unused signal.
    logic unused_d;
    assign unused_d = ^DATA_W'(D);

    logic              pvalid_m;
    logic              pvalid_s;
    state_t            state;
    state_t            state_nxt_c;
    logic              access_c;

    logic              ctrl_en;
    logic              ctrl_irq_en;
    logic              ctrl_reload;
    logic [DATA_W-1:0] load_q;
    logic [DATA_W-1:0] count_q;
    logic              expired;

    logic              wr_ctrl_c;
    logic              wr_load_c;
    logic              w1c_expired_c;
    logic              rd_c;
    logic [DATA_W-1:0] rdata_c;
    logic [DATA_W-1:0] count_nxt_c;
    logic              expired_nxt_c;

    // Two-flop synchronizer for the request crossing from the bridge domain.
    always_ff @(posedge pmu_clk or negedge pmu_resetn) begin
        if (!pmu_resetn) begin
            pvalid_m <= 1'b0;
            pvalid_s <= 1'b0;
        end else begin
            pvalid_m <= pmu_pvalid;
            pvalid_s <= pvalid_m;
        end
    end

    // Handshake state register.
    always_ff @(posedge pmu_clk or negedge pmu_resetn) begin
        if (!pmu_resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt_c;
        end
    end

    // Handshake next state; ACK waits for the request to drop so one
    // handshake yields exactly one access.
    always_comb begin
        state_nxt_c = state;
        access_c    = 1'b0;
        case (state)
            ST_IDLE:   if (pvalid_s) state_nxt_c = ST_ACCESS;
            ST_ACCESS: begin
                access_c    = 1'b1;
                state_nxt_c = ST_ACK;
            end
            ST_ACK:    if (!pvalid_s) state_nxt_c = ST_IDLE;
            default:   state_nxt_c = ST_IDLE;
        endcase
    end

    // Access decode and read mux.
    always_comb begin
        wr_ctrl_c     = access_c && pmu_pwrite && (pmu_paddr == ADDR_CTRL);
        wr_load_c     = access_c && pmu_pwrite && (pmu_paddr == ADDR_LOAD);
        w1c_expired_c = access_c && pmu_pwrite && (pmu_paddr == ADDR_STATUS) && pmu_pwdata[0];
        rd_c          = access_c && !pmu_pwrite;
        rdata_c       = '0;
        case (pmu_paddr)
            ADDR_CTRL:   rdata_c = {(DATA_W-3)'(0), ctrl_reload, ctrl_irq_en, ctrl_en};
            ADDR_LOAD:   rdata_c = load_q;
            ADDR_COUNT:  rdata_c = count_q;
            ADDR_STATUS: rdata_c = {(DATA_W-1)'(0), expired};
            ADDR_ID:     rdata_c = PMU_ID;
            default:     rdata_c = '0;
        endcase
    end

    // Timer: a LOAD write overrides the decrement; the 1->0 step sets expired
    // (winning over a same-cycle W1C) and optionally reloads from LOAD.
    always_comb begin
        count_nxt_c   = count_q;
        expired_nxt_c = expired;
        if (w1c_expired_c) begin
            expired_nxt_c = 1'b0;
        end
        if (wr_load_c) begin
            count_nxt_c = pmu_pwdata;
        end else if (ctrl_en && (count_q != '0)) begin
            if (count_q == DATA_W'(1)) begin
                count_nxt_c   = ctrl_reload ? load_q : '0;
                expired_nxt_c = 1'b1;
            end else begin
                count_nxt_c = count_q - DATA_W'(1);
            end
        end
    end

    // Register file, timer state and registered outputs.
    always_ff @(posedge pmu_clk or negedge pmu_resetn) begin
        if (!pmu_resetn) begin
            pmu_ack     <= 1'b0;
            pmu_prdata  <= '0;
            pmu_irq     <= 1'b0;
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            ctrl_reload <= 1'b0;
            load_q      <= '0;
            count_q     <= '0;
            expired     <= 1'b0;
        end else begin
            pmu_ack <= (state_nxt_c == ST_ACK);
            if (rd_c) begin
                pmu_prdata <= rdata_c;
            end
            if (wr_ctrl_c) begin
                ctrl_en     <= pmu_pwdata[0];
                ctrl_irq_en <= pmu_pwdata[1];
                ctrl_reload <= pmu_pwdata[2];
            end
            if (wr_load_c) begin
                load_q <= pmu_pwdata;
            end
            count_q <= count_nxt_c;
            expired <= expired_nxt_c;
            pmu_irq <= expired & ctrl_irq_en;
        end
    end

endmodule

// File: tb/tb_pmu_regs.sv
// tb_pmu_regs: directed bench for pmu_regs. Each access pushes its expected
// pmu_prdata into a queue; a monitor pops and compares on every pmu_ack rise.
// Accesses are issued back-to-back, so access edges are 7 pmu_clk edges apart
// and timer values below are hand-computed from that spacing.
module tb_pmu_regs;

    localparam logic [31:0] ID_VAL   = 32'h504D_0001;
    localparam logic [5:0]  A_CTRL   = 6'h00;
    localparam logic [5:0]  A_LOAD   = 6'h01;
    localparam logic [5:0]  A_COUNT  = 6'h02;
    localparam logic [5:0]  A_STATUS = 6'h03;
    localparam logic [5:0]  A_ID     = 6'h04;
    localparam logic [5:0]  A_UNMAP  = 6'h0F;

    logic        pmu_clk    = 1'b0;
    logic        pmu_resetn = 1'b1;
    logic        pmu_pvalid = 1'b0;
    logic        pmu_pwrite = 1'b0;
    logic [7:2]  pmu_paddr  = '0;
    logic [31:0] pmu_pwdata = '0;
    logic        pmu_ack;
    logic [31:0] pmu_prdata;
    logic        pmu_irq;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] exp_prdata = '0;

    always #5 pmu_clk = ~pmu_clk;

    pmu_regs dut (
        .pmu_clk    (pmu_clk),
        .pmu_resetn (pmu_resetn),
        .pmu_pvalid (pmu_pvalid),
        .pmu_pwrite (pmu_pwrite),
        .pmu_paddr  (pmu_paddr),
        .pmu_pwdata (pmu_pwdata),
        .pmu_ack    (pmu_ack),
        .pmu_prdata (pmu_prdata),
        .pmu_irq    (pmu_irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Count pmu_clk edges until pmu_ack reaches the given level (bounded).
    task automatic wait_ack(input logic level, output int n);
        n = 0;
        do begin
            @(posedge pmu_clk);
            #1;
            n++;
        end while ((pmu_ack !== level) && (n < 20));
    endtask

    // One full 4-phase handshake, with ack rise/fall latency checks.
    task automatic access(input string name, input logic wr, input logic [5:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rexp);
        int n;
        @(negedge pmu_clk);
        pmu_pwrite = wr;
        pmu_paddr  = addr;
        pmu_pwdata = wdata;
        if (!wr) exp_prdata = rexp;
        exp_q.push_back(exp_prdata);
        name_q.push_back(name);
        pmu_pvalid = 1'b1;
        wait_ack(1'b1, n);
        check({name, "_ack_rise_edges"}, 32'(n), 32'd4);
        @(negedge pmu_clk);
        pmu_pvalid = 1'b0;
        wait_ack(1'b0, n);
        check({name, "_ack_fall_edges"}, 32'(n), 32'd3);
    endtask

    task automatic wr(input string name, input logic [5:0] addr, input logic [31:0] data);
        access(name, 1'b1, addr, data, 32'h0);
    endtask

    task automatic rd(input string name, input logic [5:0] addr, input logic [31:0] exp);
        access(name, 1'b0, addr, 32'h0, exp);
    endtask

    // Scoreboard monitor: one expected pmu_prdata per acknowledged access.
    initial begin : monitor
        logic [31:0] e;
        string       nm;
        forever begin
            @(posedge pmu_ack);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=ack prdata=0x%08h required=no_ack", pmu_prdata);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check({nm, "_prdata"}, pmu_prdata, e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        #2 pmu_resetn = 1'b0;
        repeat (3) @(negedge pmu_clk);
        check("reset_ack", 32'(pmu_ack), 32'd0);
        check("reset_prdata", pmu_prdata, 32'd0);
        check("reset_irq", 32'(pmu_irq), 32'd0);
        @(negedge pmu_clk);
        pmu_resetn = 1'b1;

        // ID and reset register values.
        rd("rd_id", A_ID, ID_VAL);
        rd("rd_ctrl_rst", A_CTRL, 32'h0);
        rd("rd_load_rst", A_LOAD, 32'h0);
        rd("rd_count_rst", A_COUNT, 32'h0);
        rd("rd_status_rst", A_STATUS, 32'h0);

        // One-shot: LOAD=5 at a0, CTRL=3 at a0+14, COUNT hits 0 at a0+19.
        wr("os_load", A_LOAD, 32'd5);
        rd("os_count_loaded", A_COUNT, 32'd5);
        wr("os_ctrl", A_CTRL, 32'd3);
        repeat (2) begin @(posedge pmu_clk); #1; end
        check("os_irq_before", 32'(pmu_irq), 32'd0);
        @(posedge pmu_clk); #1;
        check("os_irq_after", 32'(pmu_irq), 32'd1);
        rd("os_count_zero", A_COUNT, 32'd0);
        rd("os_status_set", A_STATUS, 32'd1);
        rd("os_ctrl", A_CTRL, 32'd3);
        wr("os_w1c", A_STATUS, 32'd1);
        check("os_irq_cleared", 32'(pmu_irq), 32'd0);
        rd("os_status_clr", A_STATUS, 32'd0);
        rd("os_count_hold", A_COUNT, 32'd0);
        wr("os_ctrl_off", A_CTRL, 32'd0);

        // Auto-reload: LOAD=2 at b0, CTRL=5 at b0+7; COUNT alternates 2,1.
        wr("ar_load", A_LOAD, 32'd2);
        wr("ar_ctrl", A_CTRL, 32'd5);
        rd("ar_count_a", A_COUNT, 32'd2);
        rd("ar_count_b", A_COUNT, 32'd1);
        rd("ar_status", A_STATUS, 32'd1);
        check("ar_irq_masked", 32'(pmu_irq), 32'd0);
        wr("ar_ctrl_off", A_CTRL, 32'd0);
        rd("ar_count_frozen", A_COUNT, 32'd2);
        rd("ar_count_frozen2", A_COUNT, 32'd2);

        // Collision: W1C lands on the same edge as the 1->0 step (c0+21).
        wr("col_w1c_pre", A_STATUS, 32'd1);
        wr("col_load", A_LOAD, 32'd7);
        wr("col_ctrl", A_CTRL, 32'd1);
        wr("col_w1c", A_STATUS, 32'd1);
        rd("col_status", A_STATUS, 32'd1);

        // LOAD write beats a same-cycle decrement; clearing en freezes COUNT.
        wr("lw_load1", A_LOAD, 32'h100);
        wr("lw_load2", A_LOAD, 32'h200);
        rd("lw_count", A_COUNT, 32'h1FA);
        wr("lw_ctrl_off", A_CTRL, 32'd0);
        rd("lw_count_frozen", A_COUNT, 32'h1F2);
        rd("lw_load", A_LOAD, 32'h200);

        // Unmapped, read-only and reserved-bit behaviour.
        wr("um_write", A_UNMAP, 32'hFFFF_FFFF);
        rd("um_read", A_UNMAP, 32'h0);
        rd("um_ctrl", A_CTRL, 32'h0);
        rd("um_load", A_LOAD, 32'h200);
        rd("um_count", A_COUNT, 32'h1F2);
        rd("um_status", A_STATUS, 32'd1);
        wr("ro_count_wr", A_COUNT, 32'hDEAD_BEEF);
        rd("ro_count_rd", A_COUNT, 32'h1F2);
        wr("ro_id_wr", A_ID, 32'h0);
        rd("ro_id_rd", A_ID, ID_VAL);
        wr("ctrl_hi_wr", A_CTRL, 32'hFFFF_FFF8);
        rd("ctrl_hi_rd", A_CTRL, 32'h0);

        // irq follows expired & irq_en; W1C with data 0 is a no-op.
        check("irq_pre", 32'(pmu_irq), 32'd0);
        wr("irq_en_wr", A_CTRL, 32'd2);
        check("irq_enabled", 32'(pmu_irq), 32'd1);
        rd("irq_ctrl", A_CTRL, 32'd2);
        wr("w1c_zero", A_STATUS, 32'd0);
        rd("w1c_zero_status", A_STATUS, 32'd1);
        wr("w1c_one", A_STATUS, 32'd1);
        check("irq_w1c", 32'(pmu_irq), 32'd0);
        rd("w1c_one_status", A_STATUS, 32'd0);

        // Reset during ACK with pvalid held through release.
        @(negedge pmu_clk);
        pmu_pwrite = 1'b0;
        pmu_paddr  = A_LOAD;
        exp_prdata = 32'h200;
        exp_q.push_back(exp_prdata);
        name_q.push_back("rst_pre");
        pmu_pvalid = 1'b1;
        wait_ack(1'b1, n);
        check("rst_pre_ack_rise_edges", 32'(n), 32'd4);
        @(negedge pmu_clk);
        pmu_resetn = 1'b0;
        #1;
        check("rst_mid_ack", 32'(pmu_ack), 32'd0);
        check("rst_mid_prdata", pmu_prdata, 32'd0);
        check("rst_mid_irq", 32'(pmu_irq), 32'd0);
        exp_prdata = 32'h0;
        exp_q.push_back(exp_prdata);
        name_q.push_back("rst_reaccess");
        repeat (2) @(negedge pmu_clk);
        pmu_resetn = 1'b1;
        wait_ack(1'b1, n);
        check("rst_reaccess_ack_rise_edges", 32'(n), 32'd4);
        @(negedge pmu_clk);
        pmu_pvalid = 1'b0;
        wait_ack(1'b0, n);
        check("rst_reaccess_ack_fall_edges", 32'(n), 32'd3);
        repeat (12) @(posedge pmu_clk);
        rd("rst_ctrl", A_CTRL, 32'h0);
        rd("rst_count", A_COUNT, 32'h0);
        rd("rst_status", A_STATUS, 32'h0);
        check("rst_irq", 32'(pmu_irq), 32'd0);

        repeat (5) @(posedge pmu_clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pmu_regs.md
PMU_REGS -- requirements
Module: pmu_regs

Interface
REQ-001 Parameter D, default 0: register-assignment delay for simulation only; it has no functional effect.
REQ-002 Parameter PMU_ID, default 32'h504D_0001: value returned by the ID register.
REQ-003 The block SHALL have one clock, pmu_clk (input, 1): the slow PMU clock. All state is rising-edge clocked.
REQ-004 pmu_resetn (input, 1) SHALL be an asynchronous, active-low reset.
REQ-005 pmu_pvalid (input, 1): access request from the APB-domain bridge. It is asynchronous to pmu_clk.
REQ-006 pmu_pwrite (input, 1): 1 = write, 0 = read. Held stable by the source while pmu_pvalid or pmu_ack is high.
REQ-007 pmu_paddr (input, [7:2]): word address. Same stability rule as pmu_pwrite.
REQ-008 pmu_pwdata (input, 32): write data. Same stability rule as pmu_pwrite.
REQ-009 pmu_ack (output, 1): handshake acknowledge, driven directly from a register.
REQ-010 pmu_prdata (output, 32): read data, driven directly from a register.
REQ-011 pmu_irq (output, 1): wakeup-timer interrupt, level, driven directly from a register.

Function
REQ-012 pmu_pvalid SHALL pass through a 2-flop synchronizer; the second-stage output is pvalid_s.
REQ-013 The handshake FSM SHALL have three states: IDLE, ACCESS and ACK.
- IDLE -> ACCESS when pvalid_s = 1.
- ACCESS -> ACK unconditionally.
- ACK -> IDLE when pvalid_s = 0.
REQ-014 ACCESS SHALL last exactly one cycle. In that cycle:
- a write updates the addressed register;
- a read loads the register value into pmu_prdata.
REQ-015 pmu_ack SHALL be 1 exactly while the FSM is in ACK (set on entry, cleared on the exit edge).
REQ-016 Latency: pmu_ack SHALL rise on the 4th pmu_clk edge after pmu_pvalid rises. It SHALL fall on the 3rd edge after pmu_pvalid falls.
REQ-017 Each 4-phase handshake SHALL perform exactly one access. A new access SHALL only start after pvalid_s has been seen low in ACK.
REQ-018 pmu_prdata SHALL change only in a read ACCESS cycle. Writes leave it unchanged, so it is stable while pmu_ack = 1.
REQ-019 Register map (byte offset = {paddr, 2'b00}):
- 0x00 CTRL, RW: bit0 en, bit1 irq_en, bit2 reload.
- 0x04 LOAD, RW, 32 bits.
- 0x08 COUNT, RO.
- 0x0C STATUS, bit0 expired, W1C.
- 0x10 ID, RO, returns PMU_ID.
REQ-020 CTRL bits [31:3] SHALL read 0. STATUS bits [31:1] SHALL read 0.
REQ-021 Unmapped offsets SHALL read 0, and writes to them SHALL be ignored. Writes to COUNT and ID SHALL be ignored.
REQ-022 A write to LOAD SHALL update LOAD and COUNT in the same cycle.
REQ-023 Timer, when en = 1 and COUNT != 0: COUNT SHALL decrement by 1 each cycle.
REQ-024 When COUNT steps 1 -> 0, expired SHALL be set in the same edge. In that edge:
- if reload = 1, COUNT SHALL load LOAD instead of 0;
- if reload = 1 and LOAD = 0, COUNT SHALL become 0 and stop.
REQ-025 COUNT = 0 with en = 1 and reload = 0 SHALL hold at 0 and SHALL NOT re-set expired.
REQ-026 Clearing en SHALL freeze COUNT at its current value.
REQ-027 If a LOAD write and a decrement occur in the same cycle, the LOAD write SHALL win.
REQ-028 If a hardware set of expired and a W1C of expired occur in the same cycle, the set SHALL win.
REQ-029 pmu_irq SHALL equal the registered value of (expired & irq_en), i.e. one cycle after either operand changes.
REQ-030 COUNT SHALL NOT underflow or wrap below 0.

Reset
REQ-031 While pmu_resetn = 0, the following SHALL all be 0: synchronizer flops, pmu_ack, pmu_prdata, pmu_irq, CTRL, LOAD, COUNT and STATUS; the FSM SHALL be in IDLE.
REQ-032 Reset asserted mid-handshake SHALL abort the access and clear pmu_ack at once. After release, the FSM SHALL start a new access only on a fresh pvalid_s = 1.
REQ-033 Reset release SHALL take effect at the first pmu_clk edge after pmu_resetn rises.

Verification
REQ-034 ID read: pvalid with pwrite = 0, paddr = 6'h04 -> pmu_ack rises on the 4th edge; pmu_prdata = 32'h504D_0001; pmu_ack drops 3 edges after pvalid falls.
REQ-035 Timer one-shot: write LOAD = 5, then CTRL = 3 -> COUNT reads 5,4,3,2,1,0; expired = 1; pmu_irq = 1 one cycle later; W1C 0x0C with data 1 -> expired = 0 and pmu_irq = 0.
REQ-036 Timer auto-reload: LOAD = 2, CTRL = 5 -> COUNT sequence 2,1,2,1...; expired set on the first wrap; pmu_irq stays 0 because irq_en = 0.
REQ-037 Collision: issue the W1C of STATUS in the same cycle COUNT steps 1 -> 0 -> expired remains 1.
REQ-038 Reset during ACK: pulse pmu_resetn low while pmu_ack = 1 -> pmu_ack = 0 and all registers = 0; with pvalid held high through release, exactly one new access occurs.
REQ-039 Unmapped access: write 32'hFFFF_FFFF to 0x3C, then read it -> pmu_prdata = 0 and no register changes.
